// File: rtl/clk_div_monitor.sv
// rtl/clk_div_monitor.sv - slow-clock edge strobes, period/high-time meter and lock monitor (optional CLK_DIV_MONITOR_SYNC_EN input synchronizer)
module clk_div_monitor #(
    parameter int CNT_W    = 8,
    parameter int LOCK_CNT = 4,
    parameter int TOL      = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_in,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             locked,
    output logic             lost
);
    typedef enum logic [1:0] {IDLE, MEASURE, TRACK, LOCKED} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W+1)'(TOL);
    localparam logic [3:0]       LOCK_W  = 4'(LOCK_CNT);

    logic smp;
    logic prev;
    logic armed;

`ifdef CLK_DIV_MONITOR_SYNC_EN
    logic sync1;
    logic sync2;

    // Two-flop synchronizer; left out of reset so a high clk_in stays high across reset
    always_ff @(posedge clk) begin
        sync1 <= clk_in;
        sync2 <= sync1;
    end
    assign smp = sync2;
`else
    assign smp = clk_in;
`endif

    state_t           state;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [3:0]       mcnt;
    logic [3:0]       mcnt_inc;
    logic [CNT_W:0]   diff;
    logic             rise;
    logic             fall;
    logic             match;
    logic             timeout;

    // armed holds off a rise until clk_in has been seen low after reset
    assign rise     = smp & ~prev & armed;
    assign fall     = ~smp & prev;
    // pcnt is the newly measured period whenever rise is high
    assign diff     = (pcnt >= period) ? ({1'b0, pcnt} - {1'b0, period})
                                       : ({1'b0, period} - {1'b0, pcnt});
    assign match    = (diff <= TOL_W);
    assign mcnt_inc = mcnt + 4'd1;
    assign timeout  = (state != IDLE) && (pcnt == CNT_MAX) && !rise;

    // Edge detection and registered edge strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= 1'b0;
            armed      <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            prev       <= smp;
            rise_pulse <= rise;
            fall_pulse <= fall;
            if (!smp) begin
                armed <= 1'b1;
            end
        end
    end

    // Period and high-time counters: restart at 1 on a rise, saturate at max
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
            hcnt <= '0;
        end else begin
            if (rise) begin
                pcnt <= CNT_ONE;
            end else if (pcnt != CNT_MAX) begin
                pcnt <= pcnt + CNT_ONE;
            end
            if (rise) begin
                hcnt <= CNT_ONE;
            end else if (smp && (hcnt != CNT_MAX)) begin
                hcnt <= hcnt + CNT_ONE;
            end
        end
    end

    // Measurement and lock FSM; a rise wins over a timeout in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            period       <= '0;
            high_time    <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
            mcnt         <= '0;
        end else begin
            lost <= 1'b0;
            if (fall && (state != IDLE)) begin
                high_time <= hcnt;
            end
            if (rise) begin
                case (state)
                    IDLE: begin
                        state <= MEASURE;
                    end
                    MEASURE: begin
                        period       <= pcnt;
                        period_valid <= 1'b1;
                        mcnt         <= '0;
                        state        <= TRACK;
                    end
                    TRACK: begin
                        period <= pcnt;
                        if (match) begin
                            mcnt <= mcnt_inc;
                            if (mcnt_inc == LOCK_W) begin
                                locked <= 1'b1;
                                state  <= LOCKED;
                            end
                        end else begin
                            mcnt <= '0;
                        end
                    end
                    LOCKED: begin
                        period <= pcnt;
                        if (!match) begin
                            locked <= 1'b0;
                            lost   <= 1'b1;
                            mcnt   <= '0;
                            state  <= TRACK;
                        end
                    end
                endcase
            end else if (timeout) begin
                lost         <= (state == LOCKED);
                locked       <= 1'b0;
                period_valid <= 1'b0;
                state        <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb/tb_clk_div_monitor.sv - randomized and directed bench for clk_div_monitor against an event-level reference model
module tb_clk_div_monitor;
`ifdef CLK_DIV_MONITOR_SYNC_EN
    localparam bit SYNC = 1'b1;
    localparam int LAT  = 2;
`else
    localparam bit SYNC = 1'b0;
    localparam int LAT  = 0;
`endif
    localparam int LOCK = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       clk_in;
    logic       rp0, fp0, pv0, lk0, ls0;
    logic [3:0] per0, hi0;
    logic       rp1, fp1, pv1, lk1, ls1;
    logic [7:0] per1, hi1;

    clk_div_monitor #(.CNT_W(4), .LOCK_CNT(LOCK), .TOL(0)) dut0 (
        .clk(clk), .reset(reset), .clk_in(clk_in),
        .rise_pulse(rp0), .fall_pulse(fp0), .period(per0), .high_time(hi0),
        .period_valid(pv0), .locked(lk0), .lost(ls0)
    );

    clk_div_monitor #(.CNT_W(8), .LOCK_CNT(LOCK), .TOL(2)) dut1 (
        .clk(clk), .reset(reset), .clk_in(clk_in),
        .rise_pulse(rp1), .fall_pulse(fp1), .period(per1), .high_time(hi1),
        .period_valid(pv1), .locked(lk1), .lost(ls1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: edge-indexed rise times, per instance
    int   m_tol[2] = '{0, 2};
    int   m_max[2] = '{15, 255};
    int   n = 0;
    logic h1 = 1'b0;
    logic h2 = 1'b0;
    bit   m_prev[2], m_armed[2], m_rise[2], m_fall[2], m_valid[2], m_locked[2], m_lost[2];
    int   m_rises[2], m_last[2], m_period[2], m_high[2], m_mcnt[2];

    task automatic model_edge(input logic v, input logic r);
        logic s;
        int   p;
        int   d;
        bit   rise;
        bit   fall;
        bit   match;
        n++;
        s  = SYNC ? h2 : v;
        h2 = h1;
        h1 = v;
        for (int i = 0; i < 2; i++) begin
            if (r) begin
                m_prev[i] = 0; m_armed[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
                m_valid[i] = 0; m_locked[i] = 0; m_lost[i] = 0;
                m_rises[i] = 0; m_period[i] = 0; m_high[i] = 0; m_mcnt[i] = 0;
            end else begin
                rise = s && !m_prev[i] && m_armed[i];
                fall = !s && m_prev[i];
                p = n - m_last[i];
                if (p > m_max[i]) p = m_max[i];
                m_lost[i] = 0;
                if (fall && m_rises[i] > 0) m_high[i] = p;
                if (rise) begin
                    if (m_rises[i] == 1) begin
                        m_period[i] = p;
                        m_valid[i]  = 1;
                        m_mcnt[i]   = 0;
                    end else if (m_rises[i] >= 2) begin
                        d = p - m_period[i];
                        if (d < 0) d = -d;
                        match = (d <= m_tol[i]);
                        m_period[i] = p;
                        if (m_locked[i]) begin
                            if (!match) begin
                                m_locked[i] = 0;
                                m_lost[i]   = 1;
                                m_mcnt[i]   = 0;
                            end
                        end else begin
                            m_mcnt[i] = match ? m_mcnt[i] + 1 : 0;
                            if (m_mcnt[i] == LOCK) m_locked[i] = 1;
                        end
                    end
                    if (m_rises[i] < 2) m_rises[i]++;
                    m_last[i] = n;
                end else if (m_rises[i] > 0 && (n - m_last[i]) >= m_max[i]) begin
                    m_lost[i]   = m_locked[i];
                    m_locked[i] = 0;
                    m_valid[i]  = 0;
                    m_rises[i]  = 0;
                end
                m_rise[i] = rise;
                m_fall[i] = fall;
                m_prev[i] = s;
                if (!s) m_armed[i] = 1;
            end
        end
    endtask

    function automatic logic [20:0] obs(input int i);
        if (i == 0) return {rp0, fp0, 4'd0, per0, 4'd0, hi0, pv0, lk0, ls0};
        return {rp1, fp1, per1, hi1, pv1, lk1, ls1};
    endfunction

    function automatic logic [20:0] expv(input int i);
        return {m_rise[i], m_fall[i], 8'(m_period[i]), 8'(m_high[i]), m_valid[i], m_locked[i], m_lost[i]};
    endfunction

    function automatic logic lvl(input int c, input int hi, input int per);
        return ((c % per) < hi);
    endfunction

    task automatic step(input logic v, input logic r);
        clk_in = v;
        reset  = r;
        @(posedge clk);
        model_edge(v, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_outputs inst%0d: got %h expected 0", i, obs(i));
            end
        end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== expv(i)) begin
                n_fail++;
                $display("FAIL reset_model inst%0d: got %h expected %h", i, obs(i), expv(i));
            end
        end
    endtask

    task automatic test_latency();
        int d = 0;
        do_reset();
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        while (!rp0 && d < 10) begin
            step(1'b1, 1'b0);
            d++;
        end
        n_checks++;
        if (d !== LAT) begin
            n_fail++;
            $display("FAIL rise_latency: got %0d extra cycles expected %0d", d, LAT);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        d = 0;
        step(1'b0, 1'b0);
        while (!fp0 && d < 10) begin
            step(1'b0, 1'b0);
            d++;
        end
        n_checks++;
        if (d !== LAT) begin
            n_fail++;
            $display("FAIL fall_latency: got %0d extra cycles expected %0d", d, LAT);
        end
    endtask

    task automatic test_div4();
        int nr = 0;
        do_reset();
        for (int c = 0; c < 48; c++) begin
            step(lvl(c, 2, 4), 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL div4_model inst%0d cyc%0d: got %h expected %h", i, c, obs(i), expv(i));
                end
            end
            if (rp0) begin
                nr++;
                if (nr == 2) begin
                    n_checks++;
                    if ({per0, hi0, pv0} !== {4'd4, 4'd2, 1'b1}) begin
                        n_fail++;
                        $display("FAIL div4_second_rise: got period=%0d high=%0d valid=%0d expected 4 2 1", per0, hi0, pv0);
                    end
                end
                if (nr == 5 || nr == 6) begin
                    n_checks++;
                    if (lk0 !== (nr == 6)) begin
                        n_fail++;
                        $display("FAIL div4_lock rise%0d: got locked=%0d expected %0d", nr, lk0, nr == 6);
                    end
                end
            end
        end
        n_checks++;
        if (nr < 6) begin
            n_fail++;
            $display("FAIL div4_rise_count: got %0d expected at least 6", nr);
        end
    endtask

    task automatic test_odd();
        int nr = 0;
        do_reset();
        for (int c = 0; c < 40; c++) begin
            step(lvl(c, 1, 3), 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL odd_model inst%0d cyc%0d: got %h expected %h", i, c, obs(i), expv(i));
                end
            end
            if (rp0) begin
                nr++;
                if (nr == 2) begin
                    n_checks++;
                    if ({per0, hi0} !== {4'd3, 4'd1}) begin
                        n_fail++;
                        $display("FAIL odd_second_rise: got period=%0d high=%0d expected 3 1", per0, hi0);
                    end
                end
                if (nr == 5 || nr == 6) begin
                    n_checks++;
                    if (lk0 !== (nr == 6)) begin
                        n_fail++;
                        $display("FAIL odd_lock rise%0d: got locked=%0d expected %0d", nr, lk0, nr == 6);
                    end
                end
            end
        end
    endtask

    task automatic test_ratio_change();
        int   nr = 0;
        bit   chk_next = 0;
        logic v;
        do_reset();
        for (int c = 0; c < 72; c++) begin
            v = (c < 28) ? lvl(c, 2, 4) : ((c < 30) ? 1'b0 : lvl(c - 30, 3, 6));
            step(v, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL ratio_model inst%0d cyc%0d: got %h expected %h", i, c, obs(i), expv(i));
                end
            end
            if (chk_next) begin
                chk_next = 0;
                n_checks++;
                if (ls0 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ratio_lost_width: got lost=%0d expected 0", ls0);
                end
            end
            if (rp0) begin
                nr++;
                if (nr == 8) begin
                    chk_next = 1;
                    n_checks++;
                    if ({ls0, lk0, per0, lk1, ls1, per1} !== {1'b1, 1'b0, 4'd6, 1'b1, 1'b0, 8'd6}) begin
                        n_fail++;
                        $display("FAIL ratio_switch: got lost=%0d locked=%0d period=%0d tol_locked=%0d tol_lost=%0d tol_period=%0d expected 1 0 6 1 0 6",
                                 ls0, lk0, per0, lk1, ls1, per1);
                    end
                end
                if (nr == 11 || nr == 12) begin
                    n_checks++;
                    if (lk0 !== (nr == 12)) begin
                        n_fail++;
                        $display("FAIL ratio_relock rise%0d: got locked=%0d expected %0d", nr, lk0, nr == 12);
                    end
                end
            end
            if (nr >= 6) begin
                n_checks++;
                if (lk1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ratio_tol_hold cyc%0d: got locked=%0d expected 1", c, lk1);
                end
            end
        end
    endtask

    task automatic test_stopped();
        int since = 0;
        int nls0 = 0;
        int nls1 = 0;
        int nr2 = 0;
        do_reset();
        for (int c = 0; c < 310; c++) begin
            step((c < 30) ? lvl(c, 2, 4) : 1'b0, 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL stop_model inst%0d cyc%0d: got %h expected %h", i, c, obs(i), expv(i));
                end
            end
            if (rp0) since = 0;
            else since++;
            if (ls0) begin
                nls0++;
                n_checks++;
                if (since !== 15) begin
                    n_fail++;
                    $display("FAIL stop_timeout_small: got %0d cycles after last rise expected 15", since);
                end
            end
            if (ls1) begin
                nls1++;
                n_checks++;
                if (since !== 255) begin
                    n_fail++;
                    $display("FAIL stop_timeout_wide: got %0d cycles after last rise expected 255", since);
                end
            end
        end
        n_checks++;
        if ({nls0, nls1} !== {32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL stop_lost_count: got %0d and %0d expected 1 and 1", nls0, nls1);
        end
        n_checks++;
        if ({pv0, lk0, per0, hi0, pv1, lk1} !== {1'b0, 1'b0, 4'd4, 4'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL stop_idle: got valid=%0d locked=%0d period=%0d high=%0d valid1=%0d locked1=%0d expected 0 0 4 2 0 0",
                     pv0, lk0, per0, hi0, pv1, lk1);
        end
        for (int c = 0; c < 40; c++) begin
            step(lvl(c, 2, 4), 1'b0);
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (obs(i) !== expv(i)) begin
                    n_fail++;
                    $display("FAIL restart_model inst%0d cyc%0d: got %h expected %h", i, c, obs(i), expv(i));
                end
            end
            if (rp0) begin
                nr2++;
                if (nr2 == 5 || nr2 == 6) begin
                    n_checks++;
                    if (lk0 !== (nr2 == 6)) begin
                        n_fail++;
                        $display("FAIL restart_lock rise%0d: got locked=%0d expected %0d", nr2, lk0, nr2 == 6);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        int d = 0;
        do_reset();
        for (int c = 0; c < 30; c++) step(lvl(c, 2, 4), 1'b0);
        n_checks++;
        if (lk0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_prelock: got locked=%0d expected 1", lk0);
        end
        step(1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== 21'd0) begin
                n_fail++;
                $display("FAIL midreset_outputs inst%0d: got %h expected 0", i, obs(i));
            end
        end
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0);
            n_checks++;
            if ({rp0, rp1} !== 2'b00) begin
                n_fail++;
                $display("FAIL midreset_no_rise cyc%0d: got %b expected 00", c, {rp0, rp1});
            end
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        while (!rp0 && d < 8) begin
            step(1'b1, 1'b0);
            d++;
        end
        n_checks++;
        if (rp0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_rise_after_low: got no rise within %0d cycles expected a rise", d);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (obs(i) !== expv(i)) begin
                n_fail++;
                $display("FAIL midreset_model inst%0d: got %h expected %h", i, obs(i), expv(i));
            end
        end
    endtask

    task automatic test_random();
        int   hi;
        int   lo;
        int   reps;
        int   mode;
        int   len;
        logic v;
        logic r;
        do_reset();
        for (int seg = 0; seg < 40; seg++) begin
            hi   = $urandom_range(1, 5);
            lo   = $urandom_range(1, 5);
            reps = $urandom_range(1, 7);
            mode = $urandom_range(0, 11);
            len  = (mode == 0) ? 20 : reps * (hi + lo);
            for (int c = 0; c < len; c++) begin
                v = (mode == 0) ? 1'b0 : lvl(c, hi, hi + lo);
                r = (mode == 1) && (c == 0);
                step(v, r);
                for (int i = 0; i < 2; i++) begin
                    n_checks++;
                    if (obs(i) !== expv(i)) begin
                        n_fail++;
                        $display("FAIL random_model inst%0d seg%0d cyc%0d: got %h expected %h", i, seg, c, obs(i), expv(i));
                    end
                end
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        clk_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_div4();
        test_odd();
        test_ratio_change();
        test_stopped();
        test_reset_mid_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Fast-domain monitor that consumes a divided clock and measures it, acting as the receiving end of a clock divider. It samples the slow clock `clk_in` with `clk` and emits single-cycle rise/fall strobes. It measures period and high time in `clk` cycles, and declares lock once the period is stable. It sits beside divider outputs for clock-enable generation and divider health checking.

## Interface
- `CNT_W`, default 8: width of the period and high-time counters and results.
- `LOCK_CNT`, default 4: number of consecutive matching periods required before lock; range 1..15.
- `TOL`, default 0: allowed absolute period difference, in `clk` cycles, for a period to count as matching.

- `clk` input 1: sampling clock. Reset is synchronous, active-high on `reset`; the clock is `clk`.
- `reset` input 1: synchronous, active-high reset.
- `clk_in` input 1: divided or slow clock under measurement.
- `rise_pulse` output 1: one-cycle strobe per detected rising edge of `clk_in`.
- `fall_pulse` output 1: one-cycle strobe per detected falling edge of `clk_in`.
- `period` output CNT_W: last measured rise-to-rise interval, in `clk` cycles.
- `high_time` output CNT_W: last measured rise-to-fall interval, in `clk` cycles.
- `period_valid` output 1: `period` holds a real measurement.
- `locked` output 1: period has been stable for `LOCK_CNT` consecutive compares.
- `lost` output 1: one-cycle strobe when lock is dropped.

## Operation
- **Sample and edges**
  - `smp` is the sampled `clk_in` (see Configuration); `prev` is `smp` delayed by one `clk`.
  - Rise = `smp & ~prev`; fall = `~smp & prev`.
  - `rise_pulse` and `fall_pulse` are registered copies of these.
- **Period counter `pcnt`**
  - Loads 1 on a rise; otherwise increments, saturating at 2^CNT_W−1.
  - On a rise, the measured value is the old `pcnt`.
- **High counter `hcnt`**
  - Loads 1 on a rise; increments while `smp` is high, saturating.
  - On a fall, `high_time` <= `hcnt`.
  - A fall seen in IDLE does not update `high_time`.
- **FSM states:** IDLE, MEASURE, TRACK, LOCKED.
  - **IDLE:** on rise -> MEASURE; no period update.
  - **MEASURE:** on rise, `period` <= old `pcnt`, `period_valid` <= 1, `mcnt` <= 0, then -> TRACK.
  - **TRACK:** on rise, compare new against `period`.
    - Match when |new − period| <= TOL: `mcnt`++.
    - Mismatch: `mcnt` <= 0.
    - In both cases `period` <= new.
    - When the incremented `mcnt` equals `LOCK_CNT`: `locked` <= 1, -> LOCKED.
  - **LOCKED:** on rise, `period` <= new.
    - On mismatch: `locked` <= 0, `lost` <= 1 for one cycle, `mcnt` <= 0, -> TRACK.
- **Timeout** (any state except IDLE): `pcnt` is at max and no rise occurs this cycle.
  - -> IDLE, `period_valid` <= 0, `locked` <= 0.
  - `lost` pulses only if the state was LOCKED.
  - `period` and `high_time` retain their last values.
- **Simultaneous events:** a rise takes priority over timeout in the same cycle.
- **Difference arithmetic:** computed at CNT_W+1 bits, so there is no wrap.

## Timing
- **Reset values:** all outputs 0; state IDLE; `pcnt`, `hcnt`, `mcnt` = 0; `prev` = 0.
- **Reset mid-operation:** reset clears state on the next `clk` edge regardless of state. A `clk_in` held high through reset yields no `rise_pulse` until it has first been sampled low.
- **Edge latency:** `clk_in` is first sampled high at edge k.
  - `rise_pulse` is high in the cycle after edge k+L, where L = 0 without the macro and L = 2 with it.
  - `fall_pulse` has the same latency.
- **Output timing:** `period`, `period_valid`, `locked` and `lost` update on the same edge that registers `rise_pulse`.
- **Input rate:** minimum measurable period is 2 `clk` cycles. Faster `clk_in` is undefined, with no error flag.

## Configuration
- **`CLK_DIV_MONITOR_SYNC_EN` defined:** `clk_in` passes through a 2-flop synchronizer before `smp`. `clk_in` may be asynchronous to `clk`. Edge latency +2 cycles.
- **Not defined:** `smp` = `clk_in` directly. `clk_in` must be synchronous to `clk`, for example a divider output in the same domain. Measured values are identical apart from the latency.

## Test plan
- **Divide-by-4 lock:** `clk_in` = `clk`/4 from a synchronous divider, LOCK_CNT=4.
  - `period`=4 and `high_time`=2 after the 2nd rise.
  - `period_valid`=1 at the 2nd rise.
  - `locked`=1 on the 6th rise.
- **Odd ratio / duty:** `clk_in` high 1, low 2 (period 3).
  - `period`=3, `high_time`=1.
  - Lock on the 6th rise.
- **Ratio change:** locked at period 4, switch to period 6, TOL=0.
  - At the first 6-period rise: `lost`=1 for one cycle, `locked`=0, `period`=6.
  - Relock after 4 further matching rises.
  - Repeat with TOL=2: lock is held throughout.
- **Stopped clock:** locked at period 4, hold `clk_in` low, CNT_W=4.
  - Timeout when `pcnt` reaches 15: `lost` pulses, `period_valid`=0, state IDLE.
  - Restarting `clk_in` relocks on the 6th rise.
- **Reset mid-lock:** assert `reset` for 1 cycle while locked.
  - All outputs 0 on the next edge.
  - With `clk_in` high at release, no `rise_pulse` until after a low sample.
- **Macro latency:** run the same stimulus with and without `CLK_DIV_MONITOR_SYNC_EN`.
  - `rise_pulse` is offset by exactly 2 cycles.
  - `period` and `high_time` sequences are identical.
